// File: rtl/ntt_stage_scheduler.sv
// Address/control sequencer for an N-point forward NTT, one butterfly/cycle.
// Optional macro NTT_SCHED_HOLD_EN adds a 'hold' input that pauses issue.
module ntt_stage_scheduler #(
  parameter int LOG_N  = 8,
  parameter int RD_LAT = 1,
  parameter int BF_LAT = 1
) (
  input  logic             clk_100Mhz,
  input  logic             rst_n,
  input  logic             start,
`ifdef NTT_SCHED_HOLD_EN
  input  logic             hold,
`endif
  output logic             busy,
  output logic             done,
  output logic [3:0]       stage,
  output logic             rd_en,
  output logic [LOG_N-1:0] rd_addr_a,
  output logic [LOG_N-1:0] rd_addr_b,
  output logic [LOG_N-1:0] tw_addr,
  output logic             bf_valid,
  output logic             wr_en,
  output logic [LOG_N-1:0] wr_addr_a,
  output logic [LOG_N-1:0] wr_addr_b
);

  localparam int N    = 1 << LOG_N;
  localparam int NW   = LOG_N + 1;
  localparam int PIPE = RD_LAT + BF_LAT;
  localparam int CW   = $clog2(PIPE + 1) + 1;

  localparam logic [3:0]       LAST_S  = 4'(LOG_N - 1);
  localparam logic [3:0]       LOG_N4  = 4'(LOG_N);
  localparam logic [LOG_N-1:0] LAST_P  = LOG_N'(N / 2 - 1);
  localparam logic [CW-1:0]    DRAIN_N = CW'(PIPE);

  typedef enum logic [1:0] {
    S_IDLE, S_ISSUE, S_DRAIN, S_DONE
  } state_t;

  state_t state_q, state_d;

  logic [3:0]       s_q, s_d;
  logic [LOG_N-1:0] p_q, p_d;
  logic [CW-1:0]    cnt_q, cnt_d;

  logic             rd_en_q, rd_en_d;
  logic [LOG_N-1:0] ra_q, ra_d;
  logic [LOG_N-1:0] rb_q, rb_d;
  logic [LOG_N-1:0] tw_q, tw_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic [PIPE-1:0]  vld_q, vld_d;
  logic [LOG_N-1:0] wa_q [PIPE];
  logic [LOG_N-1:0] wa_d [PIPE];
  logic [LOG_N-1:0] wb_q [PIPE];
  logic [LOG_N-1:0] wb_d [PIPE];

  logic             hold_i;
  logic             issue;
  logic [3:0]       iss_s;
  logic [LOG_N-1:0] iss_p;
  logic [LOG_N:0]   len, g, o, a, b, k;

`ifdef NTT_SCHED_HOLD_EN
  assign hold_i = hold;
`else
  assign hold_i = 1'b0;
`endif

  // Next-state: each edge may issue one pair; DRAIN also covers the last-read cycle
  always_comb begin
    state_d = state_q;
    s_d     = s_q;
    p_d     = p_q;
    cnt_d   = cnt_q;
    issue   = 1'b0;
    iss_s   = s_q;
    iss_p   = p_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          issue   = 1'b1;
          iss_s   = '0;
          iss_p   = '0;
          s_d     = '0;
          p_d     = LOG_N'(1);
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (!hold_i) begin
          issue = 1'b1;
          p_d   = p_q + LOG_N'(1);
          if (p_q == LAST_P) begin
            state_d = S_DRAIN;
            cnt_d   = '0;
          end
        end
      end
      S_DRAIN: begin
        if (cnt_q == DRAIN_N) begin
          if (s_q < LAST_S) begin
            issue   = 1'b1;
            iss_s   = s_q + 4'd1;
            iss_p   = '0;
            s_d     = s_q + 4'd1;
            p_d     = LOG_N'(1);
            state_d = S_ISSUE;
          end else begin
            state_d = S_DONE;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Butterfly addressing for the pair issued this edge
  always_comb begin
    len = NW'(N) >> (iss_s + 4'd1);
    g   = {1'b0, iss_p} >> (LAST_S - iss_s);
    o   = {1'b0, iss_p} & (len - NW'(1));
    a   = (g << (LOG_N4 - iss_s)) + o;
    b   = a + len;
    k   = (NW'(1) << iss_s) + g;
    rd_en_d = issue;
    ra_d    = issue ? a[LOG_N-1:0] : '0;
    rb_d    = issue ? b[LOG_N-1:0] : '0;
    tw_d    = issue ? k[LOG_N-1:0] : '0;
    busy_d  = (state_d == S_ISSUE) || (state_d == S_DRAIN);
    done_d  = (state_d == S_DONE);
  end

  // Delay lines align valid strobes and write addresses with the pipeline
  always_comb begin
    vld_d = {vld_q[PIPE-2:0], rd_en_q};
    wa_d[0] = ra_q;
    wb_d[0] = rb_q;
    for (int i = 1; i < PIPE; i++) begin
      wa_d[i] = wa_q[i-1];
      wb_d[i] = wb_q[i-1];
    end
  end

  // State, counters, registered outputs and delay lines
  always_ff @(posedge clk_100Mhz or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      s_q     <= '0;
      p_q     <= '0;
      cnt_q   <= '0;
      rd_en_q <= 1'b0;
      ra_q    <= '0;
      rb_q    <= '0;
      tw_q    <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      vld_q   <= '0;
      for (int i = 0; i < PIPE; i++) begin
        wa_q[i] <= '0;
        wb_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      s_q     <= s_d;
      p_q     <= p_d;
      cnt_q   <= cnt_d;
      rd_en_q <= rd_en_d;
      ra_q    <= ra_d;
      rb_q    <= rb_d;
      tw_q    <= tw_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      vld_q   <= vld_d;
      for (int i = 0; i < PIPE; i++) begin
        wa_q[i] <= wa_d[i];
        wb_q[i] <= wb_d[i];
      end
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign stage     = s_q;
  assign rd_en     = rd_en_q;
  assign rd_addr_a = ra_q;
  assign rd_addr_b = rb_q;
  assign tw_addr   = tw_q;
  assign bf_valid  = vld_q[RD_LAT-1];
  assign wr_en     = vld_q[PIPE-1];
  assign wr_addr_a = wa_q[PIPE-1];
  assign wr_addr_b = wb_q[PIPE-1];

endmodule

// File: tb/tb_ntt_stage_scheduler.sv
// Directed bench for ntt_stage_scheduler: LOG_N=3 sequences,
// restart/reset handling, and a full default-size (LOG_N=8) transform.
module tb_ntt_stage_scheduler;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start3 = 1'b0;
  logic start8 = 1'b0;
  int   checks = 0;
  int   errors = 0;

  logic       busy3, done3, rd3, bfv3, wr3;
  logic [3:0] stg3;
  logic [2:0] ra3, rb3, tw3, wa3, wb3;

  logic       busy8, done8, rd8, bfv8, wr8;
  logic [3:0] stg8;
  logic [7:0] ra8, rb8, tw8, wa8, wb8;

  always #5 clk = ~clk;

  ntt_stage_scheduler #(.LOG_N(3), .RD_LAT(1), .BF_LAT(1)) dut3 (
    .clk_100Mhz(clk), .rst_n(rst_n), .start(start3),
`ifdef NTT_SCHED_HOLD_EN
    .hold(1'b0),
`endif
    .busy(busy3), .done(done3), .stage(stg3), .rd_en(rd3),
    .rd_addr_a(ra3), .rd_addr_b(rb3), .tw_addr(tw3),
    .bf_valid(bfv3), .wr_en(wr3),
    .wr_addr_a(wa3), .wr_addr_b(wb3)
  );

  ntt_stage_scheduler dut8 (
    .clk_100Mhz(clk), .rst_n(rst_n), .start(start8),
`ifdef NTT_SCHED_HOLD_EN
    .hold(1'b0),
`endif
    .busy(busy8), .done(done8), .stage(stg8), .rd_en(rd8),
    .rd_addr_a(ra8), .rd_addr_b(rb8), .tw_addr(tw8),
    .bf_valid(bfv8), .wr_en(wr8),
    .wr_addr_a(wa8), .wr_addr_b(wb8)
  );

  int ea [12] = '{0,1,2,3, 0,1,4,5, 0,2,4,6};
  int eb [12] = '{4,5,6,7, 2,3,6,7, 1,3,5,7};
  int ek [12] = '{1,1,1,1, 2,2,3,3, 4,5,6,7};

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic bit is_rd(input int c);
    return (c >= 1) && (c <= 18) && (((c - 1) % 6) < 4);
  endfunction

  function automatic int pidx(input int c);
    return ((c - 1) / 6) * 4 + ((c - 1) % 6);
  endfunction

  // One LOG_N=3 transform; optionally pulses start in cycle pulse_c
  task automatic run3(input int pulse_c);
    start3 = 1'b1;
    @(negedge clk);
    for (int c = 1; c <= 20; c++) begin
      start3 = (c == pulse_c);
      chk($sformatf("rd_en c%0d", c), 32'(rd3), 32'(is_rd(c)));
      if (is_rd(c)) begin
        chk($sformatf("rd_a c%0d", c), 32'(ra3), ea[pidx(c)]);
        chk($sformatf("rd_b c%0d", c), 32'(rb3), eb[pidx(c)]);
        chk($sformatf("tw c%0d", c), 32'(tw3), ek[pidx(c)]);
        chk($sformatf("stage c%0d", c), 32'(stg3), (c - 1) / 6);
      end
      chk($sformatf("bf_valid c%0d", c), 32'(bfv3), 32'(is_rd(c - 1)));
      chk($sformatf("wr_en c%0d", c), 32'(wr3), 32'(is_rd(c - 2)));
      if (is_rd(c - 2)) begin
        chk($sformatf("wr_a c%0d", c), 32'(wa3), ea[pidx(c - 2)]);
        chk($sformatf("wr_b c%0d", c), 32'(wb3), eb[pidx(c - 2)]);
      end
      chk($sformatf("done c%0d", c), 32'(done3), 32'(c == 19));
      chk($sformatf("busy c%0d", c), 32'(busy3), 32'(c <= 18));
      @(negedge clk);
    end
    start3 = 1'b0;
  endtask

  initial begin
    int cyc, rdc, wrc, done_cyc;
    int la, lb, lk;

    repeat (2) @(negedge clk);
    chk("rst rd_en3", 32'(rd3), 0);
    chk("rst busy3", 32'(busy3), 0);
    chk("rst done3", 32'(done3), 0);
    chk("rst wr_en3", 32'(wr3), 0);
    chk("rst stage3", 32'(stg3), 0);
    chk("rst busy8", 32'(busy8), 0);
    rst_n = 1'b1;
    @(negedge clk);

    run3(0);
    run3(8);

    start3 = 1'b1;
    @(negedge clk);
    start3 = 1'b0;
    repeat (10) @(negedge clk);
    chk("pre-rst wr_en c11", 32'(wr3), 1);
    chk("pre-rst busy c11", 32'(busy3), 1);
    rst_n = 1'b0;
    #1;
    chk("mid-rst rd_en", 32'(rd3), 0);
    chk("mid-rst wr_en", 32'(wr3), 0);
    chk("mid-rst busy", 32'(busy3), 0);
    chk("mid-rst bf_valid", 32'(bfv3), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run3(0);

    start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    cyc = 1;
    rdc = 0;
    wrc = 0;
    done_cyc = -1;
    la = -1; lb = -1; lk = -1;
    while (cyc < 2000 && done_cyc < 0) begin
      if (rd8) begin
        rdc++;
        la = int'(ra8); lb = int'(rb8); lk = int'(tw8);
      end
      if (wr8) wrc++;
      if (done8) done_cyc = cyc;
      else begin
        @(negedge clk);
        cyc++;
      end
    end
    chk("n256 done cycle", done_cyc, 1041);
    chk("n256 rd count", rdc, 1024);
    chk("n256 wr count", wrc, 1024);
    chk("n256 last rd_a", la, 254);
    chk("n256 last rd_b", lb, 255);
    chk("n256 last tw", lk, 255);
    chk("n256 busy at done", 32'(busy8), 0);
    @(negedge clk);
    chk("n256 busy after", 32'(busy8), 0);
    chk("n256 done after", 32'(done8), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ntt_stage_scheduler.md
Name: ntt_stage_scheduler

Overview:
- Address/control sequencer that drives the 24-bit 2x2 NTT butterfly over a full N-point forward NTT, mod q = 8380417.
- Iterates LOG_N stages at one butterfly per cycle and generates the coefficient-RAM read/write addresses and the twiddle-ROM index.
- Aligns write-back with the read and butterfly pipeline latency, and drains between stages to avoid RAW hazards.
- Sits between the top-level PA controller and the coefficient RAM, twiddle ROM and butterfly. It carries no data itself.

Parameters:
- LOG_N, 8, log2 of transform size; N = 2^LOG_N. Legal range 2..15.
- RD_LAT, 1, coefficient RAM and twiddle ROM read latency in cycles (>=1).
- BF_LAT, 1, butterfly input-to-output latency in cycles (>=1).

Ports:
- clk_100Mhz  input  1  system clock.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  begin transform; sampled only in IDLE.
- busy  output  1  high in ISSUE/DRAIN.
- done  output  1  one-cycle pulse at end of transform.
- stage  output  4  current stage index s.
- rd_en  output  1  RAM/ROM read strobe.
- rd_addr_a  output  LOG_N  upper-leg read address j.
- rd_addr_b  output  LOG_N  lower-leg read address j+len.
- tw_addr  output  LOG_N  twiddle ROM index k.
- bf_valid  output  1  butterfly inputs valid; rd_en delayed RD_LAT cycles.
- wr_en  output  1  write-back strobe.
- wr_addr_a  output  LOG_N  write address for Fi_0.
- wr_addr_b  output  LOG_N  write address for Fi_1.

Behaviour:
- Reset (asynchronous, immediate): state=IDLE. All outputs 0. Counters and delay lines cleared. In-flight writes are discarded. Applies mid-transform too.
- FSM states are IDLE, ISSUE, DRAIN and DONE.
  - IDLE: start=1 moves to ISSUE with s=0, p=0.
  - ISSUE: each cycle, rd_en=1 with addresses for pair p, then p++. After p=N/2-1 is issued, move to DRAIN.
  - DRAIN: wait exactly PIPE=RD_LAT+BF_LAT cycles with rd_en=0. Then, if s<LOG_N-1: s++, p=0, back to ISSUE. Otherwise go to DONE.
  - DONE: done=1 and busy=0 for one cycle, then IDLE.
- Address math, all outputs registered:
  - len = N>>(s+1)
  - g = p>>(LOG_N-1-s)
  - o = p&(len-1)
  - rd_addr_a = 2*len*g + o
  - rd_addr_b = rd_addr_a + len
  - tw_addr = 2^s + g, so k runs 1..N-1 across the transform.
- Pipeline alignment:
  - A read issued in cycle t gives bf_valid at t+RD_LAT.
  - wr_en=1 at t+PIPE, with wr_addr_a/b equal to the rd_addr_a/b from cycle t, carried by a PIPE-deep shift register.
- Latency: start sampled at edge 0, first rd_en in cycle 1. Stage length is N/2+PIPE cycles. done is high in cycle 1 + LOG_N*(N/2+PIPE). For defaults that is cycle 1041.
- Start handling: start is ignored in ISSUE, DRAIN and DONE. start held high continuously restarts from IDLE, one cycle after DONE.
- busy rises in the cycle of the first rd_en and falls with done.
- No two writes in a stage touch the same address. Stage s+1 reads begin only after the last stage-s write lands.

Optional Feature:
- Macro NTT_SCHED_HOLD_EN.
- When defined: adds input port hold (1 bit).
  - hold=1 in ISSUE: rd_en=0 and p/s are frozen.
  - The bf_valid/wr_en/write-address delay lines keep shifting, so in-flight butterflies still write back.
  - DRAIN, DONE and IDLE ignore hold.
  - Total latency grows by the number of held ISSUE cycles.
- When undefined: there is no hold port and ISSUE never pauses.

Test Plan:
- LOG_N=3, RD_LAT=1, BF_LAT=1, pulse start → read sequence (a,b,k):
  - stage 0: (0,4,1)(1,5,1)(2,6,1)(3,7,1)
  - stage 1: (0,2,2)(1,3,2)(4,6,3)(5,7,3)
  - stage 2: (0,1,4)(2,3,5)(4,5,6)(6,7,7)
  - Each stage separated by 2 idle cycles. done in cycle 19.
- Same config → each wr_en occurs exactly 2 cycles after its rd_en, with identical addresses. bf_valid occurs exactly 1 cycle after rd_en. 12 writes total.
- Defaults (LOG_N=8) → 1024 rd_en, 1024 wr_en, done exactly in cycle 1041. Final stage's last read is (254,255,255). busy is low after done.
- start pulsed again during ISSUE of stage 1 → ignored; sequence and done timing unchanged.
- rst_n low in stage 1 DRAIN → rd_en, wr_en, busy=0 immediately. After release, start yields a clean stage-0 sequence from p=0.
- With NTT_SCHED_HOLD_EN, LOG_N=3, hold high for 3 cycles after the 2nd stage-0 read → reads resume with (2,6,1). The 2nd read's write still lands 2 cycles after its read. done in cycle 22.
